// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: timekeeping controller for the lab digital clock.
// A prescaler derives a one-second strobe from clk. The strobe steps the
// seconds/minutes/hours chain while in RUN. A four-state mode FSM, stepped by
// mode_btn, lets the user set hours and minutes with inc_btn and clear seconds.
module clock_set_ctrl #(
    parameter int TICKS_PER_SEC = 4,
    parameter int SEC_MAX       = 59,
    parameter int MIN_MAX       = 59,
    parameter int HOUR_MAX      = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] seconds,
    output logic [5:0] minutes,
    output logic [4:0] hours,
    output logic       tick_sec,
    output logic       tick_min,
    output logic [1:0] mode
);

    // The prescaler is at least one bit wide, so TICKS_PER_SEC == 1 still
    // builds. In that case it sits at 0 and the strobe fires every RUN cycle.
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    SEC_LAST   = 6'(SEC_MAX);
    localparam logic [5:0]    MIN_LAST   = 6'(MIN_MAX);
    localparam logic [4:0]    HOUR_LAST  = 5'(HOUR_MAX);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } mode_t;

    mode_t         state;
    mode_t         state_nxt;
    logic [PW-1:0] presc;
    logic          mode_q;
    logic          inc_q;
    logic          mode_press;
    logic          inc_press;
    logic          sec_last;
    logic          min_last;
    logic          hour_last;

    // Rising-edge detection on the already-debounced button levels. If mode
    // and inc rise together, mode wins and the inc press is dropped.
    assign mode_press = mode_btn & ~mode_q;
    assign inc_press  = inc_btn & ~inc_q & ~mode_press;

    assign sec_last  = (seconds == SEC_LAST);
    assign min_last  = (minutes == MIN_LAST);
    assign hour_last = (hours == HOUR_LAST);

    assign mode = state;

    // Button history. Reset loads 1, so a button held through reset must be
    // released before it can register a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b1;
            inc_q  <= 1'b1;
        end else begin
            mode_q <= mode_btn;
            inc_q  <= inc_btn;
        end
    end

    // Mode FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Mode FSM next state: each mode press advances RUN -> SET_H -> SET_M -> SET_S -> RUN.
    always_comb begin
        state_nxt = state;
        if (mode_press) begin
            case (state)
                RUN:     state_nxt = SET_H;
                SET_H:   state_nxt = SET_M;
                SET_M:   state_nxt = SET_S;
                SET_S:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Strobes are decoded only from registered state. They are masked during
    // reset so that no strobe leaks out of the reset cycle.
    always_comb begin
        tick_sec = 1'b0;
        tick_min = 1'b0;
        if (!reset && state == RUN && presc == PRESC_LAST) begin
            tick_sec = 1'b1;
            tick_min = sec_last;
        end
    end

    // The prescaler runs only while RUN is both the current and next state.
    // It is 0 in every SET state, so the first second after leaving SET_S
    // lasts a full TICKS_PER_SEC cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
        end else if (state == RUN && state_nxt == RUN) begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end else begin
            presc <= '0;
        end
    end

    // Time registers: a ripple-carry chain on the strobe in RUN, and direct
    // edits from inc presses in the SET states. Setting minutes never carries.
    always_ff @(posedge clk) begin
        if (reset) begin
            seconds <= '0;
            minutes <= '0;
            hours   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (tick_sec) begin
                        seconds <= sec_last ? 6'd0 : seconds + 6'd1;
                    end
                    if (tick_min) begin
                        minutes <= min_last ? 6'd0 : minutes + 6'd1;
                        if (min_last) begin
                            hours <= hour_last ? 5'd0 : hours + 5'd1;
                        end
                    end
                end
                SET_H: begin
                    if (inc_press) begin
                        hours <= hour_last ? 5'd0 : hours + 5'd1;
                    end
                end
                SET_M: begin
                    if (inc_press) begin
                        minutes <= min_last ? 6'd0 : minutes + 6'd1;
                    end
                end
                SET_S: begin
                    if (inc_press) begin
                        seconds <= 6'd0;
                    end
                end
                default: begin
                    seconds <= seconds;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: the test-plan sequences followed by random button
// and reset traffic. Every cycle is checked against a model that keeps the time
// as one integer count of seconds.
module tb_clock_set_ctrl;

    localparam int T        = 4;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 15;
    localparam int SECS     = SEC_MAX + 1;
    localparam int MINS     = MIN_MAX + 1;
    localparam int HRS      = HOUR_MAX + 1;
    localparam int DAY      = HRS * MINS * SECS;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       tick_sec;
    logic       tick_min;
    logic [1:0] mode;

    clock_set_ctrl #(
        .TICKS_PER_SEC(T),
        .SEC_MAX(SEC_MAX),
        .MIN_MAX(MIN_MAX),
        .HOUR_MAX(HOUR_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode_btn(mode_btn),
        .inc_btn(inc_btn),
        .seconds(seconds),
        .minutes(minutes),
        .hours(hours),
        .tick_sec(tick_sec),
        .tick_min(tick_min),
        .mode(mode)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state. m_time counts seconds since 0:0:0. m_run counts cycles
    // spent in RUN since RUN was last entered.
    bit m_valid = 0;
    int m_time  = 0;
    int m_mode  = 0;
    int m_run   = 0;
    bit m_mq    = 1;
    bit m_iq    = 1;

    // Values seen in the most recent step; used by the literal checks.
    int obs_sec, obs_min, obs_hr, obs_mode;
    bit obs_ts, obs_tm;
    int n_ts, n_tm;

    task automatic chk(input string nm, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check the outputs against the model,
    // then advance the model exactly as the next rising edge will.
    task automatic step(input bit r, input bit mb, input bit ib);
        int s, mn, h;
        bit et, em, mp, ip;
        @(negedge clk);
        reset = r;
        mode_btn = mb;
        inc_btn = ib;
        #1;
        s  = m_time % SECS;
        mn = (m_time / SECS) % MINS;
        h  = m_time / (SECS * MINS);
        et = !r && m_mode == 0 && (m_run % T == T - 1);
        em = et && s == SEC_MAX;
        if (m_valid) begin
            chk("seconds", int'(seconds), s);
            chk("minutes", int'(minutes), mn);
            chk("hours", int'(hours), h);
            chk("mode", int'(mode), m_mode);
            chk("tick_sec", int'(tick_sec), int'(et));
            chk("tick_min", int'(tick_min), int'(em));
        end
        obs_sec = seconds; obs_min = minutes; obs_hr = hours; obs_mode = mode;
        obs_ts = tick_sec; obs_tm = tick_min;
        if (tick_sec) n_ts++;
        if (tick_min) n_tm++;
        if (r) begin
            m_valid = 1; m_time = 0; m_mode = 0; m_run = 0; m_mq = 1; m_iq = 1;
        end else begin
            mp = mb && !m_mq;
            ip = ib && !m_iq && !mp;
            if (m_mode == 0) begin
                if (et) m_time = (m_time + 1) % DAY;
                m_run = mp ? 0 : (m_run + 1) % T;
                if (mp) m_mode = 1;
            end else if (mp) begin
                m_mode = (m_mode + 1) % 4;
                m_run = 0;
            end else if (ip) begin
                case (m_mode)
                    1: h = (h + 1) % HRS;
                    2: mn = (mn + 1) % MINS;
                    default: s = 0;
                endcase
                m_time = (h * MINS + mn) * SECS + s;
            end
            m_mq = mb;
            m_iq = ib;
        end
    endtask

    task automatic tap_mode();
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    task automatic tap_inc(input int n);
        for (int k = 0; k < n; k++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
    endtask

    initial begin
        bit rb, mb, ib;

        // Reset, then 16 RUN cycles: strobes on cycles 4, 8, 12 and 16.
        step(1, 0, 0);
        n_ts = 0; n_tm = 0;
        for (int i = 0; i < 16; i++) step(0, 0, 0);
        chk("pin_tick_sec_count_16", n_ts, 4);
        chk("pin_tick_min_count_16", n_tm, 0);
        step(0, 0, 0);
        chk("pin_seconds_after_16", obs_sec, 4);

        // Preload 15:59:00, return to RUN, then run to 15:59:58.
        tap_mode();
        tap_inc(15);
        tap_mode();
        tap_inc(59);
        tap_mode();
        tap_inc(1);
        chk("pin_set_s_clears", obs_sec, 0);
        tap_mode();
        for (int i = 0; i < 231; i++) step(0, 0, 0);
        step(0, 0, 0);
        chk("pin_pre_sec", obs_sec, 58);
        chk("pin_pre_min", obs_min, 59);
        chk("pin_pre_hr", obs_hr, 15);
        n_tm = 0;
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        chk("pin_rollover_tick_min", n_tm, 1);
        step(0, 0, 0);
        chk("pin_rollover_sec", obs_sec, 0);
        chk("pin_rollover_min", obs_min, 0);
        chk("pin_rollover_hr", obs_hr, 0);

        // Mode and increment sequence from RUN.
        tap_mode();
        chk("pin_mode_set_h", obs_mode, 1);
        tap_inc(3);
        chk("pin_hours_3", obs_hr, 3);
        tap_mode();
        tap_inc(61);
        chk("pin_minutes_61", obs_min, 1);
        chk("pin_hours_kept", obs_hr, 3);
        tap_mode();
        tap_inc(1);
        chk("pin_seconds_cleared", obs_sec, 0);
        tap_mode();
        chk("pin_back_to_run", obs_mode, 0);

        // Simultaneous mode and inc press in SET_H: mode wins.
        tap_mode();
        step(0, 1, 1);
        step(0, 0, 0);
        chk("pin_simul_mode", obs_mode, 2);
        chk("pin_simul_hours", obs_hr, 3);
        tap_mode();
        tap_mode();

        // inc held for 10 cycles in SET_H gives one increment.
        tap_mode();
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        step(0, 0, 0);
        chk("pin_held_once", obs_hr, 4);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("pin_second_press", obs_hr, 5);
        tap_mode();
        tap_mode();
        tap_mode();

        // Reset at prescaler phase 2 with mode held through and after reset.
        step(0, 0, 0);
        step(1, 1, 0);
        chk("pin_no_strobe_in_reset", int'(obs_ts), 0);
        step(0, 1, 0);
        chk("pin_rst_sec", obs_sec, 0);
        chk("pin_rst_hr", obs_hr, 0);
        chk("pin_rst_mode", obs_mode, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        chk("pin_held_after_reset", obs_mode, 0);
        step(0, 0, 0);

        // Random button traffic with occasional resets.
        mb = 0; ib = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) mb = ~mb;
            if ($urandom_range(0, 2) == 0) ib = ~ib;
            rb = ($urandom_range(0, 299) == 0);
            step(rb, mb, ib);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
